sync_fifo_ext: RTL and testbench
================================

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, the almost_full level threshold.
REQ-004 SHALL have parameter AE_THRESH, default 2, the almost_empty level threshold.
REQ-005 SHALL use one clock and a synchronous, active-high reset, declared as follows:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of contents
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read/pop request
- dout  out  DATA_WIDTH  read data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  ADDR_WIDTH+1  current occupancy
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

Function
REQ-006 SHALL accept a write when wr_en && (!full || rd_accepted): a write while full is accepted when a read is accepted in the same cycle.
REQ-007 SHALL accept a read when rd_en && !empty; a write in the same cycle does not make an empty FIFO readable.
REQ-008 SHALL update level as level + wr_acc - rd_acc each cycle; simultaneous accepted read and write SHALL leave level unchanged.
REQ-009 SHALL wrap the read and write pointers modulo DEPTH.
REQ-010 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered level.
REQ-011 SHALL set overflow on wr_en && !wr_acc and underflow on rd_en && empty; both SHALL hold until clr_err, flush or rst.
REQ-012 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-013 SHALL, on flush, zero the pointers, level and error flags on the next edge, ignore wr_en and rd_en in that cycle, and leave memory contents undefined.
REQ-014 SHALL require AE_THRESH < AF_THRESH <= DEPTH; an elaboration-time check SHALL fail otherwise.

Reset
REQ-015 SHALL, on rst at posedge clk, clear the pointers and level to 0 and overflow and underflow to 0.
REQ-016 SHALL drive empty=1, full=0, almost_empty=1, almost_full=0 and dout=0 after reset.
REQ-017 SHALL give rst priority over flush, and flush priority over wr_en and rd_en.
REQ-018 SHALL NOT reset the memory array.

Configuration
REQ-019 SHALL have the macro SYNC_FIFO_FWFT_EN select the read mode.
REQ-020 With SYNC_FIFO_FWFT_EN undefined, dout SHALL be registered and load mem[rd_ptr] on the edge of an accepted read (1-cycle latency); dout SHALL hold otherwise.
REQ-021 With SYNC_FIFO_FWFT_EN defined, dout SHALL present the head word whenever !empty; an accepted rd_en SHALL pop it so the next word appears after the edge.
REQ-022 With SYNC_FIFO_FWFT_EN defined, dout SHALL be 0 while empty.
REQ-023 With SYNC_FIFO_FWFT_EN defined, the first word written into an empty FIFO SHALL appear on dout in the cycle after the write.

Structure
REQ-024 SHALL place the threshold-check function and the default-threshold constants in shared package sync_fifo_pkg.
REQ-025 SHALL implement storage in sub-module sync_fifo_mem, a DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port.
REQ-026 SHALL keep the pointer, level and flag logic in sync_fifo_ext.

Verification
REQ-027 SHALL cover fill and drain: write 16 words 0x00..0x0F with defaults -> full=1 and almost_full from level 14; read all 16 -> data in order, empty=1, level=0.
REQ-028 SHALL cover overflow: write while full, level=16 -> overflow=1 and level stays 16; pulse clr_err -> overflow=0.
REQ-029 SHALL cover a simultaneous write and read at full -> level stays 16, full stays 1, no overflow, and the write data is read out 16 reads later.
REQ-030 SHALL cover underflow: rd_en and wr_en together while empty -> underflow=1, level=1, and dout unchanged in standard mode.
REQ-031 SHALL cover flush: flush at level 7 with wr_en=1 -> level=0, empty=1, and the flags cleared next cycle.
REQ-032 SHALL cover FWFT mode: write 0xA5 to an empty FIFO -> dout=0xA5 one cycle later with no rd_en; rd_en -> empty=1 and dout=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_ext FIFO family:
// default geometry/threshold values and the threshold legality check.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_AE_THRESH  = 2;
  // almost_full defaults to this many entries below DEPTH
  localparam int unsigned DEF_AF_MARGIN  = 2;

  function automatic int unsigned def_af_thresh(input int unsigned addr_width);
    return (32'd1 << addr_width) - DEF_AF_MARGIN;
  endfunction

  // Thresholds must satisfy AE < AF <= DEPTH
  function automatic logic thresholds_ok(input int unsigned ae,
                                         input int unsigned af,
                                         input int unsigned depth);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ext_if.sv
// Handshake/status bundle for sync_fifo_ext. master = user side, slave = FIFO.
interface sync_fifo_ext_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write port, one
// asynchronous read port. Contents are never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port: store wdata at waddr on an accepted write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with level, almost-full/empty thresholds, sticky
// overflow/underflow flags and synchronous flush.
// Macro SYNC_FIFO_FWFT_EN: defined -> first-word-fall-through read port;
// undefined -> registered dout loaded on each accepted read.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = def_af_thresh(ADDR_WIDTH),
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_ext_if.slave bus
);

  localparam int unsigned         DEPTH  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (!thresholds_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
    $fatal(1, "sync_fifo_ext: require AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc, ovf_set, udf_set;
  logic [DATA_WIDTH-1:0] rdata;

  assign bus.full         = (level_q == DEPTH_L);
  assign bus.empty        = (level_q == '0);
  assign bus.almost_full  = (level_q >= AF_L);
  assign bus.almost_empty = (level_q <= AE_L);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Accept decisions, next pointers/level and sticky error flags
  always_comb begin
    rd_acc      = !bus.flush && bus.rd_en && !bus.empty;
    // a read in the same cycle frees a slot, so a write at full still lands
    wr_acc      = !bus.flush && bus.wr_en && (!bus.full || rd_acc);
    ovf_set     = !bus.flush && bus.wr_en && !wr_acc;
    udf_set     = !bus.flush && bus.rd_en && bus.empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d     = level_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
      overflow_d  = ovf_set || (overflow_q && !bus.clr_err);
      underflow_d = udf_set || (underflow_q && !bus.clr_err);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.dout = bus.empty ? '0 : rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  // Output register captures the head word on an accepted read, else holds
  always_comb begin
    dout_d = dout_q;
    if (rd_acc) dout_d = rdata;
  end

  // Read data register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_sync_fifo_ext;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_ext #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags and standard-mode dout
  logic [DW-1:0] q[$];
  bit            m_valid = 0;
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  always @(posedge clk) begin
    bit rd_ok, wr_ok, so, su;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_dout = '0; m_valid = 1;
    end else if (m_valid) begin
      if (bus.flush) begin
        q.delete();
        m_ovf = 0; m_udf = 0;
      end else begin
        rd_ok = bus.rd_en && (q.size() > 0);
        wr_ok = bus.wr_en && ((q.size() < DEPTH) || rd_ok);
        so    = bus.wr_en && !wr_ok;
        su    = bus.rd_en && (q.size() == 0);
        m_ovf = so || (m_ovf && !bus.clr_err);
        m_udf = su || (m_udf && !bus.clr_err);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(bus.din);
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [DW-1:0] exp_dout;
    if (m_valid) begin
`ifdef SYNC_FIFO_FWFT_EN
      exp_dout = (q.size() > 0) ? q[0] : '0;
`else
      exp_dout = m_dout;
`endif
      chk("m_level", 32'(bus.level), 32'(q.size()));
      chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("m_afull", 32'(bus.almost_full), 32'(q.size() >= AF));
      chk("m_aempty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
      chk("m_udf", 32'(bus.underflow), 32'(m_udf));
      chk("m_dout", 32'(bus.dout), 32'(exp_dout));
    end
  end

  task automatic idle();
    bus.flush = 0; bus.wr_en = 0; bus.rd_en = 0; bus.clr_err = 0; bus.din = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle();
    tick(); tick();
    rst = 0;

    // Reset state
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_dout", 32'(bus.dout), 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1; bus.din = DW'(i);
      tick();
      chk("fill_level", 32'(bus.level), 32'(i + 1));
      chk("fill_afull", 32'(bus.almost_full), 32'(i + 1 >= 14));
    end
    idle();
    chk("fill_full", 32'(bus.full), 1);

    // Overflow then clear
    bus.wr_en = 1; bus.din = 8'hEE;
    tick(); idle();
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_level", 32'(bus.level), 16);
    bus.clr_err = 1;
    tick(); idle();
    chk("ovf_clr", 32'(bus.overflow), 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_dout", 32'(bus.dout), 32'(i));
      bus.rd_en = 1; tick();
`else
      bus.rd_en = 1; tick();
      chk("drain_dout", 32'(bus.dout), 32'(i));
`endif
    end
    idle();
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_level", 32'(bus.level), 0);

    // Refill 0x10..0x1F, then simultaneous write/read at full
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1; bus.din = DW'(16 + i);
      tick();
    end
    bus.wr_en = 1; bus.rd_en = 1; bus.din = 8'h77;
    tick(); idle();
    chk("wr_rd_full_level", 32'(bus.level), 16);
    chk("wr_rd_full_full", 32'(bus.full), 1);
    chk("wr_rd_full_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("wr_rd_drain", 32'(bus.dout), (i < 15) ? 32'(8'h11 + i) : 32'h77);
      bus.rd_en = 1; tick();
`else
      bus.rd_en = 1; tick();
      chk("wr_rd_drain", 32'(bus.dout), (i < 15) ? 32'(8'h11 + i) : 32'h77);
`endif
    end
    idle();

    // Underflow: read and write together while empty
    bus.rd_en = 1; bus.wr_en = 1; bus.din = 8'h3C;
    tick(); idle();
    chk("udf_set", 32'(bus.underflow), 1);
    chk("udf_level", 32'(bus.level), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("udf_dout", 32'(bus.dout), 32'h3C);
`else
    chk("udf_dout", 32'(bus.dout), 32'h77);
`endif

    // Flush at level 7 with a write pending; underflow still set
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1; bus.din = DW'(8'h40 + i);
      tick();
    end
    idle();
    chk("pre_flush_level", 32'(bus.level), 7);
    bus.flush = 1; bus.wr_en = 1; bus.din = 8'h99;
    tick(); idle();
    chk("flush_level", 32'(bus.level), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_udf", 32'(bus.underflow), 0);

    // Set wins over clr_err in the same cycle
    bus.rd_en = 1; bus.clr_err = 1;
    tick(); idle();
    chk("set_prio_udf", 32'(bus.underflow), 1);
    bus.clr_err = 1;
    tick(); idle();
    chk("clr_udf", 32'(bus.underflow), 0);

    // Single write into empty FIFO, then pop it
    bus.wr_en = 1; bus.din = 8'hA5;
    tick(); idle();
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_dout", 32'(bus.dout), 32'hA5);
`else
    chk("std_hold_dout", 32'(bus.dout), 32'h77);
`endif
    bus.rd_en = 1;
    tick(); idle();
    chk("pop_empty", 32'(bus.empty), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_empty_dout", 32'(bus.dout), 0);
`else
    chk("std_pop_dout", 32'(bus.dout), 32'hA5);
`endif

    // Reset wins over flush and traffic
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1; bus.din = DW'(8'h50 + i);
      tick();
    end
    idle();
    rst = 1; bus.flush = 1; bus.wr_en = 1; bus.rd_en = 1; bus.din = 8'h66;
    tick();
    rst = 0; idle();
    chk("rst2_level", 32'(bus.level), 0);
    chk("rst2_dout", 32'(bus.dout), 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
